// File: rtl/ks_final_sum.sv
// ks_final_sum -- tail of the Kogge-Stone mantissa adder in the MAC pipeline.
//
// Takes the span-8 prefix results from the upstream stage and finishes the
// carry resolution in two registered stages:
//   stage A: prefix step at distance 8
//   stage B: prefix step at distance 16, then the sum XOR, carry-out and zero flag
// A two-deep valid/ready pipeline lets the normaliser stall the adder tail
// without losing data. Throughput is one bundle per cycle and latency is two cycles.
//
// Ports
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_G3, in_P3          group generate/propagate over bits i..max(i-7,0)
//   in_P0                 bitwise propagate a^b
//   in_GG                 resolved carry i:0 (only bits [7:0] are used)
//   in_sign               result sign, carried alongside the data
//   out_valid / out_ready downstream handshake
//   out_sum, out_cout     a+b mod 2^WIDTH and the carry out of the top bit
//   out_zero, out_sign    out_sum==0 flag and delayed sign
//   err_drop              sticky: a bundle was offered while in_ready was low
//
// WIDTH must lie in 17..32, because two steps only cover a carry span of 32.
module ks_final_sum #(
  parameter int WIDTH = 25
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_G3,
  input  logic [WIDTH-1:0] in_P3,
  input  logic [WIDTH-1:0] in_P0,
  input  logic [WIDTH-1:0] in_GG,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_sign,
  output logic             err_drop
);

  logic [15:0]       gg4_p0;
  logic [WIDTH-1:16] g4_p0;
  logic [WIDTH-1:16] p4_p0;

  logic [15:0]       gg4_p1;
  logic [WIDTH-1:16] g4_p1;
  logic [WIDTH-1:16] p4_p1;
  logic [WIDTH-1:0]  p0_p1;
  logic              sign_p1;
  logic              vld_p1;

  logic [WIDTH-1:0]  gg_p1;
  logic [WIDTH-1:0]  sum_p1;
  logic              vld_p2;

  logic              rdy_p1;
  logic              rdy_p2;

  // Bits below 8 of G3/P3 are already fully resolved in in_GG, and only the
  // low byte of in_GG carries a resolved carry.
  logic unused_upper;
  assign unused_upper = ^{in_GG[WIDTH-1:8], in_G3[7:0], in_P3[7:0]};

  // ---- stage p0 -> p1: prefix step at distance 8 ----
  for (genvar i = 0; i < 16; i++) begin : g_step4_lo
    if (i < 8) begin : g_pass
      assign gg4_p0[i] = in_GG[i];
    end else begin : g_resolve
      assign gg4_p0[i] = in_G3[i] | (in_P3[i] & in_GG[i-8]);
    end
  end

  for (genvar i = 16; i < WIDTH; i++) begin : g_step4_hi
    assign g4_p0[i] = in_G3[i] | (in_P3[i] & in_G3[i-8]);
    assign p4_p0[i] = in_P3[i] & in_P3[i-8];
  end

  always_ff @(posedge clock) begin
    if (rdy_p1) begin
      gg4_p1  <= gg4_p0;
      g4_p1   <= g4_p0;
      p4_p1   <= p4_p0;
      p0_p1   <= in_P0;
      sign_p1 <= in_sign;
    end
  end

  // ---- stage p1 -> p2: prefix step at distance 16, sum and flags ----
  assign gg_p1[15:0] = gg4_p1;

  for (genvar i = 16; i < WIDTH; i++) begin : g_step5
    assign gg_p1[i] = g4_p1[i] | (p4_p1[i] & gg4_p1[i-16]);
  end

  // Carry-in is zero, so bit 0 of the sum is the plain propagate bit.
  assign sum_p1 = p0_p1 ^ {gg_p1[WIDTH-2:0], 1'b0};

  // Output registers are reset so the port values read 0 while the pipe is empty.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_zero <= 1'b0;
      out_sign <= 1'b0;
    end else if (rdy_p2) begin
      out_sum  <= sum_p1;
      out_cout <= gg_p1[WIDTH-1];
      out_zero <= ~|sum_p1;
      out_sign <= sign_p1;
    end
  end

  // ---- flow control ----
  // A stage may load when it is empty or when its occupant leaves this cycle.
  assign rdy_p2    = !vld_p2 | out_ready;
  assign rdy_p1    = !vld_p1 | rdy_p2;
  assign in_ready  = rdy_p1;
  assign out_valid = vld_p2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (rdy_p1) begin
        vld_p1 <= in_valid;
      end
      if (rdy_p2) begin
        vld_p2 <= vld_p1;
      end
      if (in_valid && !rdy_p1) begin
        err_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ks_final_sum.sv
// Bench for ks_final_sum: directed vectors with hand-computed results plus a
// random stream checked against a plain A+B reference through a FIFO scoreboard.
module tb_ks_final_sum;

  localparam int W = 25;

  logic         clock;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_G3;
  logic [W-1:0] in_P3;
  logic [W-1:0] in_P0;
  logic [W-1:0] in_GG;
  logic         in_sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_zero;
  logic         out_sign;
  logic         err_drop;

  ks_final_sum #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_G3     (in_G3),
    .in_P3     (in_P3),
    .in_P0     (in_P0),
    .in_GG     (in_GG),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_sign  (out_sign),
    .err_drop  (err_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         sign;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;

  // Upstream steps 1-3 of the Kogge-Stone tree, built from scratch.
  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] ng;
    logic [W-1:0] np;
    g = a & b;
    p = a ^ b;
    in_P0 = p;
    for (int d = 1; d < 8; d = d * 2) begin
      ng = g;
      np = p;
      for (int i = d; i < W; i++) begin
        ng[i] = g[i] | (p[i] & g[i-d]);
        np[i] = p[i] & p[i-d];
      end
      g = ng;
      p = np;
    end
    in_G3   = g;
    in_P3   = p;
    in_GG   = g;
    in_sign = s;
    cur_a   = a;
    cur_b   = b;
  endtask

  // Scoreboard: the handshake happens at the next rising edge, so the
  // falling edge sees exactly what will be transferred.
  always @(negedge clock) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(out_sum), 32'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sum",  32'(out_sum),  32'(e.sum));
          chk("sb_cout", 32'(out_cout), 32'(e.cout));
          chk("sb_zero", 32'(out_zero), 32'(e.sum == '0));
          chk("sb_sign", 32'(out_sign), 32'(e.sign));
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, cur_a} + {1'b0, cur_b};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.sign = in_sign;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int accepted;
  int cycles;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in('0, '0, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_err_drop",  32'(err_drop),  32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    tick();

    // Carry ripples into bit 24 through the distance-8 and distance-16 steps.
    out_ready = 1'b1;
    set_in(25'h0FFFFFF, 25'h0000001, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_lat_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum",   32'(out_sum),   32'h1000000);
    chk("t1_cout",  32'(out_cout),  32'd0);
    chk("t1_zero",  32'(out_zero),  32'd0);
    chk("t1_sign",  32'(out_sign),  32'd1);
    tick();
    chk("t1_gone", 32'(out_valid), 32'd0);

    // Full-width wrap: sum 0, carry out, zero flag.
    set_in(25'h1FFFFFF, 25'h0000001, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_sum",   32'(out_sum),   32'h0);
    chk("t2_cout",  32'(out_cout),  32'd1);
    chk("t2_zero",  32'(out_zero),  32'd1);
    tick();

    // Three back-to-back bundles against a stalled sink.
    out_ready = 1'b0;
    set_in(25'h0123456, 25'h0654321, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("t3_rdy0", 32'(in_ready), 32'd1);
    tick();
    set_in(25'h1800000, 25'h0800000, 1'b1);
    #1;
    chk("t3_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    set_in(25'h1555555, 25'h0AAAAAA, 1'b0);
    #1;
    chk("t3_full", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_sum",   32'(out_sum),   32'h0777777);
      chk("t3_hold_rdy",   32'(in_ready),  32'd0);
      if (k < 3) tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk("t3_same_cycle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_b1_sum",  32'(out_sum),  32'h0);
    chk("t3_b1_cout", 32'(out_cout), 32'd1);
    chk("t3_b1_sign", 32'(out_sign), 32'd1);
    tick();
    chk("t3_b2_sum",  32'(out_sum),  32'h1FFFFFF);
    chk("t3_b2_cout", 32'(out_cout), 32'd0);
    tick();
    chk("t3_empty",   32'(out_valid), 32'd0);
    chk("t3_no_drop", 32'(err_drop),  32'd0);

    // Fill the pipe, then offer a bundle while it is full.
    out_ready = 1'b0;
    set_in(25'h0000F00, 25'h0000F00, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    #1;
    chk("t4_full", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t4_drop_set", 32'(err_drop), 32'd1);
    tick();
    tick();
    chk("t4_drop_sticky", 32'(err_drop), 32'd1);
    chk("t4_pre_rst_sum", 32'(out_sum),  32'h0001E00);

    // Reset with both stages occupied.
    resetn = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_sum",   32'(out_sum),   32'd0);
    chk("t5_sign",  32'(out_sign),  32'd0);
    chk("t5_drop",  32'(err_drop),  32'd0);
    sb.delete();
    tick();
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_no_stale", 32'(out_valid), 32'd0);
    end

    // Random stream with random backpressure.
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      tick();
      cycles++;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready && ($urandom_range(0, 3) != 0)) begin
        set_in(W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b1;
        accepted++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("rnd_accepted", 32'(accepted), 32'd10000);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
    chk("rnd_drained", 32'(sb.size()), 32'd0);
    chk("rnd_no_drop", 32'(err_drop),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
